// File: rtl/chacha_bus_pkg.sv
// Shared constants, FSM state enum and a word-select helper for the ChaCha bus master.
// Latency: none (package only).
// Backpressure: none (package only).
package chacha_bus_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_NONCE  = 8'h20;
  localparam logic [7:0] ADDR_DATA   = 8'h30;

  localparam logic [31:0] CMD_INIT = 32'd1;
  localparam logic [31:0] CMD_NEXT = 32'd2;
  localparam logic [31:0] CMD_DONE = 32'd4;

  localparam int STATUS_READY_BIT = 0;

  typedef enum logic [3:0] {
    IDLE,
    WR_KEY,
    WR_NONCE,
    WR_DATA,
    CMD_INIT_S,
    GAP_INIT,
    CMD_NEXT_S,
    GAP_NEXT,
    CMD_DONE_S,
    RD_REQ,
    RD_CAP,
    FINISH
  } state_t;

  // Word idx counted from the most significant end of a 256-bit vector.
  function automatic logic [31:0] word_sel(input logic [255:0] v, input logic [2:0] idx);
    return v[(8'd224 - {idx, 5'd0}) +: 32];
  endfunction

endpackage

// File: rtl/chacha_bus_master.sv
// Drives key/nonce/data writes, init/next/done commands and status polling on a ChaCha core bus.
// Latency: first bus cycle one cycle after start; done 57 cycles after start with defaults and immediate ready.
// Backpressure: none on the bus; start is ignored while busy, polling ends on ready or after POLL_MAX reads.
module chacha_bus_master
  import chacha_bus_pkg::*;
#(
  parameter int WAIT_INIT = 2,
  parameter int WAIT_NEXT = 20,
  parameter int POLL_MAX  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [63:0]  data,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data,
  output logic         busy,
  output logic         done,
  output logic [31:0]  status,
  output logic         timeout
);

  state_t        state;
  logic          phase;      // 0: bus cycle, 1: trailing idle cycle of a write
  logic [3:0]    cnt;        // word counter within the current write group
  logic [31:0]   gap_cnt;
  logic [31:0]   poll_cnt;
  logic [255:0]  key_q;
  logic [95:0]   nonce_q;
  logic [63:0]   data_q;

  logic [3:0]    nxt_idx;
  logic          wr_last;
  state_t        wr_next;
  logic [7:0]    wr_addr;
  logic [31:0]   wr_dat;

  // Select the next write (address, data, follow-on state) from the current state and word counter.
  always_comb begin
    nxt_idx = cnt + 4'd1;
    wr_last = 1'b0;
    wr_next = state;
    wr_addr = '0;
    wr_dat  = '0;
    case (state)
      WR_KEY: begin
        wr_last = (cnt == 4'd7);
        wr_next = WR_NONCE;
        if (wr_last) begin
          wr_addr = ADDR_NONCE;
          wr_dat  = nonce_q[95:64];
        end else begin
          wr_addr = ADDR_KEY + {4'd0, nxt_idx};
          wr_dat  = word_sel(key_q, nxt_idx[2:0]);
        end
      end
      WR_NONCE: begin
        wr_last = (cnt == 4'd2);
        wr_next = WR_DATA;
        if (wr_last) begin
          wr_addr = ADDR_DATA;
          wr_dat  = data_q[63:32];
        end else begin
          wr_addr = ADDR_NONCE + {4'd0, nxt_idx};
          wr_dat  = word_sel({nonce_q, 160'd0}, nxt_idx[2:0]);
        end
      end
      WR_DATA: begin
        wr_last = (cnt == 4'd1);
        wr_next = CMD_INIT_S;
        if (wr_last) begin
          wr_addr = ADDR_CTRL;
          wr_dat  = CMD_INIT;
        end else begin
          wr_addr = ADDR_DATA + 8'd1;
          wr_dat  = data_q[31:0];
        end
      end
      CMD_INIT_S, GAP_INIT: begin
        wr_addr = ADDR_CTRL;
        wr_dat  = CMD_NEXT;
      end
      CMD_NEXT_S, GAP_NEXT: begin
        wr_addr = ADDR_CTRL;
        wr_dat  = CMD_DONE;
      end
      default: ;
    endcase
  end

  // Sequencer: state advances and all bus/status outputs are registered for the coming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      cnt        <= '0;
      gap_cnt    <= '0;
      poll_cnt   <= '0;
      key_q      <= '0;
      nonce_q    <= '0;
      data_q     <= '0;
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= '0;
      timeout    <= 1'b0;
    end else begin
      // Bus returns to idle values unless a state below issues a cycle.
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= '0;
      write_data <= '0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q      <= key;
            nonce_q    <= nonce;
            data_q     <= data;
            timeout    <= 1'b0;
            busy       <= 1'b1;
            cnt        <= '0;
            phase      <= 1'b0;
            state      <= WR_KEY;
            cs         <= 1'b1;
            we         <= 1'b1;
            address    <= ADDR_KEY;
            write_data <= key[255:224];
          end
        end
        WR_KEY, WR_NONCE, WR_DATA: begin
          phase <= ~phase;
          if (phase) begin
            cs         <= 1'b1;
            we         <= 1'b1;
            address    <= wr_addr;
            write_data <= wr_dat;
            if (wr_last) begin
              cnt   <= '0;
              state <= wr_next;
            end else begin
              cnt <= nxt_idx;
            end
          end
        end
        CMD_INIT_S: begin
          phase <= ~phase;
          if (phase) begin
            if (WAIT_INIT == 0) begin
              cs         <= 1'b1;
              we         <= 1'b1;
              address    <= wr_addr;
              write_data <= wr_dat;
              state      <= CMD_NEXT_S;
            end else begin
              gap_cnt <= '0;
              state   <= GAP_INIT;
            end
          end
        end
        GAP_INIT: begin
          if (gap_cnt == 32'(WAIT_INIT - 1)) begin
            cs         <= 1'b1;
            we         <= 1'b1;
            address    <= wr_addr;
            write_data <= wr_dat;
            state      <= CMD_NEXT_S;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        CMD_NEXT_S: begin
          phase <= ~phase;
          if (phase) begin
            if (WAIT_NEXT == 0) begin
              cs         <= 1'b1;
              we         <= 1'b1;
              address    <= wr_addr;
              write_data <= wr_dat;
              state      <= CMD_DONE_S;
            end else begin
              gap_cnt <= '0;
              state   <= GAP_NEXT;
            end
          end
        end
        GAP_NEXT: begin
          if (gap_cnt == 32'(WAIT_NEXT - 1)) begin
            cs         <= 1'b1;
            we         <= 1'b1;
            address    <= wr_addr;
            write_data <= wr_dat;
            state      <= CMD_DONE_S;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        CMD_DONE_S: begin
          phase <= ~phase;
          if (phase) begin
            cs       <= 1'b1;
            address  <= ADDR_STATUS;
            poll_cnt <= '0;
            state    <= RD_REQ;
          end
        end
        RD_REQ: begin
          poll_cnt <= poll_cnt + 32'd1;
          state    <= RD_CAP;
        end
        RD_CAP: begin
          status <= read_data;
          // Ready wins even on the final permitted poll.
          if (read_data[STATUS_READY_BIT]) begin
            done  <= 1'b1;
            state <= FINISH;
          end else if (poll_cnt == 32'(POLL_MAX)) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= FINISH;
          end else begin
            cs      <= 1'b1;
            address <= ADDR_STATUS;
            state   <= RD_REQ;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_bus_master.sv
// Directed bench for chacha_bus_master: write order/data, done timing, polling, timeout, reset abort, busy start.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_chacha_bus_master;

  localparam logic [255:0] KEY   = 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_deadbeef_feedface;
  localparam logic [95:0]  NONCE = 96'h01010101_02020202_03030303;
  localparam logic [63:0]  DATA  = 64'haaaaaaaa_bbbbbbbb;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [63:0]  data;
  logic         cs;
  logic         we;
  logic [7:0]   address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         busy;
  logic         done;
  logic [31:0]  status;
  logic         timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // Monitor state (owned by the monitor process, cleared on request).
  logic [39:0] wlog[$];
  int nreads, bad_rd, ndone, done_cyc, first_cs, idle_bad, b2b;
  logic prev_cs;
  int clr_gen = 0;
  int mon_gen = 0;
  int rsp_gen = 0;

  // Bus responder configuration: read number ready_after (1-based) and later return ready_val; 0 = never ready.
  int          ready_after = 1;
  logic [31:0] ready_val = 32'h1;
  int          rd_served;

  logic [39:0] exp_wr [16];

  chacha_bus_master dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .nonce      (nonce),
    .data       (data),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Cycle counter: value k labels the cycle that follows posedge k.
  always @(posedge clk) cyc++;

  // Bus monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_gen != clr_gen) begin
      mon_gen  = clr_gen;
      wlog.delete();
      nreads   = 0;
      bad_rd   = 0;
      ndone    = 0;
      done_cyc = -1;
      first_cs = -1;
      idle_bad = 0;
      b2b      = 0;
      prev_cs  = 1'b0;
    end
    if (cs && we) wlog.push_back({address, write_data});
    if (cs && !we) begin
      nreads++;
      if (address != 8'h09) bad_rd++;
    end
    if (cs && first_cs < 0) first_cs = cyc;
    if (!cs && (we || address != 8'h00 || write_data != 32'h0)) idle_bad++;
    if (cs && prev_cs) b2b++;
    prev_cs = cs;
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  end

  // Status responder: a read seen in one cycle yields read_data during the next cycle only.
  initial begin
    logic pend;
    read_data = 32'h0;
    rd_served = 0;
    forever begin
      @(negedge clk);
      if (rsp_gen != clr_gen) begin
        rsp_gen   = clr_gen;
        rd_served = 0;
      end
      pend = cs && !we;
      @(posedge clk);
      #1;
      if (pend) begin
        rd_served++;
        read_data = (ready_after != 0 && rd_served >= ready_after) ? ready_val : 32'h0;
      end else begin
        read_data = 32'h0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    clr_gen++;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (ndone == 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({tag, "_done_seen"}, 64'(ndone != 0), 64'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 64'(wlog.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_wr%0d", tag, i), 64'((i < wlog.size()) ? wlog[i] : 40'h0), 64'(exp_wr[i]));
    end
    chk({tag, "_idle_bus"}, 64'(idle_bad), 64'd0);
    chk({tag, "_b2b_cs"}, 64'(b2b), 64'd0);
  endtask

  initial begin
    int k;
    exp_wr = '{
      {8'h10, 32'h00112233}, {8'h11, 32'h44556677}, {8'h12, 32'h8899aabb}, {8'h13, 32'hccddeeff},
      {8'h14, 32'h01234567}, {8'h15, 32'h89abcdef}, {8'h16, 32'hdeadbeef}, {8'h17, 32'hfeedface},
      {8'h20, 32'h01010101}, {8'h21, 32'h02020202}, {8'h22, 32'h03030303},
      {8'h30, 32'haaaaaaaa}, {8'h31, 32'hbbbbbbbb},
      {8'h08, 32'h00000001}, {8'h08, 32'h00000002}, {8'h08, 32'h00000004}
    };
    key   = KEY;
    nonce = NONCE;
    data  = DATA;
    rst   = 1'b1;
    start = 1'b1;   // start during reset must be ignored
    settle(3);
    start = 1'b0;
    rst   = 1'b0;
    settle(2);

    // Reset state
    chk("rst_cs", 64'(cs), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(address), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);

    // Scenarios 1/2: full sequence, ready on first poll, inputs changed after start
    ready_after = 1;
    ready_val   = 32'h1;
    clear_log();
    pulse_start();
    chk("s1_busy", 64'(busy), 64'd1);
    chk("s1_first_cs", 64'(first_cs), 64'(start_cyc + 1));
    key   = ~KEY;
    nonce = ~NONCE;
    data  = ~DATA;
    wait_done(200, "s2");
    chk("s2_done_cyc", 64'(done_cyc), 64'(start_cyc + 57));
    chk("s2_status", 64'(status), 64'h1);
    chk("s2_timeout", 64'(timeout), 64'd0);
    chk("s2_nreads", 64'(nreads), 64'd1);
    chk("s2_rd_addr", 64'(bad_rd), 64'd0);
    check_writes("s1");
    settle(2);
    chk("s2_done_pulses", 64'(ndone), 64'd1);
    chk("s2_busy_end", 64'(busy), 64'd0);
    key   = KEY;
    nonce = NONCE;
    data  = DATA;

    // Scenario 3: ready on fourth poll
    ready_after = 4;
    ready_val   = 32'h3;
    clear_log();
    pulse_start();
    wait_done(400, "s3");
    chk("s3_nreads", 64'(nreads), 64'd4);
    chk("s3_status", 64'(status), 64'h3);
    chk("s3_timeout", 64'(timeout), 64'd0);
    chk("s3_done_cyc", 64'(done_cyc), 64'(start_cyc + 63));
    settle(2);
    chk("s3_done_pulses", 64'(ndone), 64'd1);

    // Scenario 4: never ready -> timeout after 64 reads; next start clears it
    ready_after = 0;
    clear_log();
    pulse_start();
    wait_done(600, "s4");
    chk("s4_nreads", 64'(nreads), 64'd64);
    chk("s4_timeout", 64'(timeout), 64'd1);
    chk("s4_done_cyc", 64'(done_cyc), 64'(start_cyc + 183));
    chk("s4_status", 64'(status), 64'h0);
    settle(2);
    chk("s4_done_pulses", 64'(ndone), 64'd1);
    ready_after = 1;
    ready_val   = 32'h1;
    clear_log();
    pulse_start();
    chk("s4_timeout_cleared", 64'(timeout), 64'd0);
    wait_done(200, "s4b");
    chk("s4b_status", 64'(status), 64'h1);
    settle(2);

    // Scenario 5: reset during nonce writes
    clear_log();
    pulse_start();
    k = 0;
    while (!(cs && we && address == 8'h20) && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("s5_reached_nonce", 64'(k < 100), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("s5_cs", 64'(cs), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_status", 64'(status), 64'h0);
    chk("s5_no_done_before", 64'(ndone), 64'd0);
    clear_log();
    settle(80);
    chk("s5_no_writes", 64'(wlog.size()), 64'd0);
    chk("s5_no_reads", 64'(nreads), 64'd0);
    chk("s5_no_done", 64'(ndone), 64'd0);
    clear_log();
    pulse_start();
    wait_done(200, "s5");
    check_writes("s5");
    settle(2);

    // Scenario 6: start pulsed during GAP_NEXT is ignored
    clear_log();
    pulse_start();
    while (cyc < start_cyc + 40) @(negedge clk);
    #1;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done(200, "s6");
    chk("s6_done_cyc", 64'(done_cyc), 64'(start_cyc + 57));
    chk("s6_status", 64'(status), 64'h1);
    check_writes("s6");
    settle(4);
    chk("s6_done_pulses", 64'(ndone), 64'd1);
    chk("s6_busy_end", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
